// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the command-side SPI master and its optional command
// buffer: word widths, opcode encodings and the frame state encoding.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int CMD_W  = 10;  // command word: [9:8] opcode, [7:0] address/data
    localparam int DATA_W = 8;   // read-back byte
    localparam int CNT_W  = 4;   // bit/phase counter width

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,  // SS_n low, MOSI 0, lead-in before the first command bit
        ST_SHIFT,  // command bits out on MOSI, MSB first
        ST_TA,     // turnaround before read data comes back
        ST_RECV,   // read byte sampled from MISO, MSB first
        ST_GAP     // SS_n high between frames
    } state_t;

endpackage

// File: rtl/spi_cmd_buf.sv
// -----------------------------------------------------------------------------
// spi_cmd_buf
// One-entry valid/ready holding register for a pending SPI command. Lets the
// host hand over the next command while the current frame is still running.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   in_data/in_valid     command offered for storage
//   in_ready             entry is empty and can take a command
//   out_data/out_valid   stored command and its valid flag
//   out_ready            consumer takes the stored command this cycle
// -----------------------------------------------------------------------------
module spi_cmd_buf
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CMD_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             full;
    logic [CMD_W-1:0] data_q;

    // Push is only possible when empty and pop only when full, so the two
    // never collide in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
        end else if (out_ready && full) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload register has no reset; only the valid flag decides
    // whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_q <= in_data;
        end
    end

    assign in_ready  = !full;
    assign out_valid = full;
    assign out_data  = data_q;

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Command-side SPI master running on the system clock (one bit per clk, MSB
// first). Accepts 10-bit commands over valid/ready, sends them on MOSI inside
// an SS_n-low frame, and for read-data commands captures a byte from MISO.
//
// Optional feature: define SPI_MASTER_CMD_BUF_EN to compile in a one-entry
// command buffer so the next command can be accepted mid-frame and launched
// straight out of the gap.
//
// Parameters (all assumed >= 1):
//   LEAD_CYCLES  SS_n low with MOSI 0 before the first command bit
//   TA_CYCLES    turnaround between last MOSI bit and first MISO sample
//   GAP_CYCLES   minimum SS_n-high time between frames
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   cmd/cmd_valid        command from host ([9:8] opcode, [7:0] addr/data)
//   cmd_ready            command accepted when cmd_valid && cmd_ready
//   rd_data/rd_valid     captured read byte and its one-cycle strobe
//   busy                 frame in progress (SS_n low or gap pending)
//   SS_n, MOSI, MISO     serial interface to the slave
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int LEAD_CYCLES = 1,
    parameter int TA_CYCLES   = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] TA_LAST    = CNT_W'(TA_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CMD_W-1:0]  sh_q;
    logic [DATA_W-2:0] rx_q;       // first seven received bits; the eighth goes straight to rd_data
    logic              is_read_q;  // current frame is a read-data frame

    logic              accept;
    logic              launch;     // a new frame starts on this edge
    logic [CMD_W-1:0]  launch_cmd;

    assign accept = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_CMD_BUF_EN
    logic             launch_pt;
    logic             buf_in_ready;
    logic             buf_valid;
    logic             buf_push;
    logic             buf_pop;
    logic [CMD_W-1:0] buf_data;

    // A frame may start from IDLE or from the last gap cycle. A command
    // accepted exactly at such a point bypasses the buffer so that SS_n still
    // falls on the cycle after acceptance.
    assign launch_pt  = (state == ST_IDLE) || (state == ST_GAP && cnt == GAP_LAST);
    assign cmd_ready  = !rst && buf_in_ready;
    assign launch     = launch_pt && (buf_valid || accept);
    assign launch_cmd = buf_valid ? buf_data : cmd;
    assign buf_pop    = launch_pt && buf_valid;
    assign buf_push   = accept && !(launch_pt && !buf_valid);

    spi_cmd_buf u_cmd_buf (
        .clk       (clk),
        .rst       (rst),
        .in_data   (cmd),
        .in_valid  (buf_push),
        .in_ready  (buf_in_ready),
        .out_data  (buf_data),
        .out_valid (buf_valid),
        .out_ready (buf_pop)
    );
`else
    assign cmd_ready  = !rst && (state == ST_IDLE);
    assign launch     = accept;
    assign launch_cmd = cmd;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        SS_n       = 1'b1;
        MOSI       = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (launch) state_next = ST_START;
            end
            ST_START: begin
                SS_n = 1'b0;
                if (cnt == LEAD_LAST) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                SS_n = 1'b0;
                MOSI = sh_q[CMD_W-1];
                if (cnt == SHIFT_LAST) state_next = is_read_q ? ST_TA : ST_GAP;
            end
            ST_TA: begin
                SS_n = 1'b0;
                if (cnt == TA_LAST) state_next = ST_RECV;
            end
            ST_RECV: begin
                SS_n = 1'b0;
                if (cnt == RECV_LAST) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) state_next = launch ? ST_START : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sh_q      <= '0;
            rx_q      <= '0;
            is_read_q <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_next;
            // One counter serves every phase; it restarts on each state change.
            cnt      <= (state_next != state) ? '0 : cnt + CNT_W'(1);
            rd_valid <= 1'b0;

            if (launch) begin
                sh_q      <= launch_cmd;
                is_read_q <= (launch_cmd[CMD_W-1 -: 2] == CMD_RD_DATA);
            end else if (state == ST_SHIFT) begin
                sh_q <= {sh_q[CMD_W-2:0], 1'b0};
            end

            if (state == ST_RECV) begin
                rx_q <= {rx_q[DATA_W-3:0], MISO};
                // Last bit: publish the byte so the strobe lands in the first gap cycle.
                if (cnt == RECV_LAST) begin
                    rd_data  <= {rx_q, MISO};
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master with a behavioural slave + byte memory on the
// serial side. Works with and without SPI_MASTER_CMD_BUF_EN.
// -----------------------------------------------------------------------------
module tb_spi_master;
    import spi_pkg::*;

    localparam int LEAD       = 1;
    localparam int TA         = 2;
    localparam int GAP        = 1;
    localparam int FRAME_WR   = LEAD + 10;           // 11
    localparam int FRAME_RD   = LEAD + 10 + TA + 8;  // 21
    localparam int RECV_FIRST = LEAD + 10 + TA;      // low-cycle index of first MISO bit
`ifdef SPI_MASTER_CMD_BUF_EN
    localparam int  GAP_HIGH  = GAP;
    localparam bit  BUF_BUILD = 1'b1;
`else
    localparam int  GAP_HIGH  = GAP + 1;
    localparam bit  BUF_BUILD = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy;
    logic             SS_n;
    logic             MOSI;
    logic             MISO;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master #(
        .LEAD_CYCLES (LEAD),
        .TA_CYCLES   (TA),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural slave + data memory ----------------
    int         lo_cnt = 0;   // index of the current SS_n-low cycle
    logic [9:0] rx_sh = '0;
    logic [7:0] wr_addr = '0;
    logic [7:0] rd_addr = '0;
    logic [7:0] mem [256];
    logic [9:0] slave_word;

    assign slave_word = {rx_sh[8:0], MOSI};

    always @(posedge clk) begin
        if (SS_n) lo_cnt <= 0;
        else      lo_cnt <= lo_cnt + 1;
        if (!SS_n) rx_sh <= slave_word;
        if (!SS_n && lo_cnt == LEAD + 9) begin
            case (slave_word[9:8])
                CMD_WR_ADDR: wr_addr <= slave_word[7:0];
                CMD_WR_DATA: mem[wr_addr] <= slave_word[7:0];
                CMD_RD_ADDR: rd_addr <= slave_word[7:0];
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!SS_n && lo_cnt >= RECV_FIRST && lo_cnt < RECV_FIRST + 8)
            MISO <= mem[rd_addr][RECV_FIRST + 7 - lo_cnt];
        else
            MISO <= 1'b0;
    end

    // SS_n trace for spacing measurements
    bit ss_q[$];
    bit tr_on = 1'b0;
    always @(negedge clk) if (tr_on) ss_q.push_back(SS_n);

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge one cycle after acceptance.
    task automatic send_cmd(input logic [9:0] c, output bit acc_busy);
        bit ok;
        ok = 1'b0;
        acc_busy = 1'b0;
        cmd = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                acc_busy = busy;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout cmd=%h: cmd_ready never high within 200 cycles", c);
        end
    endtask

    task automatic do_frame(input logic [9:0] c, output int low_len, output logic [9:0] mosi_bits,
                            output int rv_cnt, output bit rv_at_rise, output bit mosi_clean);
        bit b;
        send_cmd(c, b);
        low_len = 0; rv_cnt = 0; mosi_bits = '0; rv_at_rise = 1'b0; mosi_clean = 1'b1;
        for (int i = 0; i < 64 && SS_n == 1'b0; i++) begin
            if (low_len >= LEAD && low_len < LEAD + 10) mosi_bits[9 - (low_len - LEAD)] = MOSI;
            else if (MOSI !== 1'b0) mosi_clean = 1'b0;
            if (rd_valid) rv_cnt++;
            low_len++;
            @(negedge clk);
        end
        rv_at_rise = rd_valid;
        if (rd_valid) rv_cnt++;
        @(negedge clk);
        if (rd_valid) rv_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; cmd = '0; cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (SS_n !== 1'b1)      begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
        n_checks++; if (MOSI !== 1'b0)      begin n_fail++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        n_checks++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 8'h00)  begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if (SS_n !== 1'b1)      begin n_fail++; $display("FAIL post_reset_ss_n: got %b want 1", SS_n); end
    endtask

    task automatic test_write_addr();
        int low_len, rv_cnt; logic [9:0] mb; bit rv_rise, clean;
        do_frame(10'h0A5, low_len, mb, rv_cnt, rv_rise, clean);
        n_checks++; if (low_len !== FRAME_WR) begin n_fail++; $display("FAIL wr_addr_low_len: got %0d want %0d", low_len, FRAME_WR); end
        n_checks++; if (mb !== 10'h0A5)       begin n_fail++; $display("FAIL wr_addr_mosi_bits: got %h want 0a5", mb); end
        n_checks++; if (clean !== 1'b1)       begin n_fail++; $display("FAIL wr_addr_mosi_idle: MOSI nonzero outside shift"); end
        n_checks++; if (rv_cnt !== 0)         begin n_fail++; $display("FAIL wr_addr_rd_valid: got %0d strobes want 0", rv_cnt); end
        n_checks++; if (rd_data !== 8'h00)    begin n_fail++; $display("FAIL wr_addr_rd_data: got %h want 00", rd_data); end
    endtask

    task automatic test_reset_mid_frame();
        bit b; int lows; int low_len, rv_cnt; logic [9:0] mb; bit rv_rise, clean;
        send_cmd(10'h300, b);
`ifdef SPI_MASTER_CMD_BUF_EN
        send_cmd(10'h0FF, b);  // parked in the buffer; must be dropped by reset
        repeat (RECV_FIRST + 4 - 1) @(negedge clk);
`else
        repeat (RECV_FIRST + 4) @(negedge clk);
`endif
        n_checks++; if (SS_n !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_active: SS_n got %b want 0", SS_n); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (SS_n !== 1'b1)      begin n_fail++; $display("FAIL midrst_ss_n: got %b want 1", SS_n); end
        n_checks++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 8'h00)  begin n_fail++; $display("FAIL midrst_rd_data: got %h want 00", rd_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_cmd_ready: got %b want 0", cmd_ready); end
        rst = 1'b0;
        lows = 0;
        repeat (6) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || rd_valid !== 1'b0) lows++;
        end
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL midrst_no_resume: %0d active cycles after reset want 0", lows); end
        do_frame(10'h1A7, low_len, mb, rv_cnt, rv_rise, clean);
        n_checks++; if (low_len !== FRAME_WR) begin n_fail++; $display("FAIL midrst_next_low_len: got %0d want %0d", low_len, FRAME_WR); end
        n_checks++; if (mb !== 10'h1A7)       begin n_fail++; $display("FAIL midrst_next_mosi: got %h want 1a7", mb); end
        n_checks++; if (rv_cnt !== 0)         begin n_fail++; $display("FAIL midrst_next_rd_valid: got %0d want 0", rv_cnt); end
    endtask

    task automatic test_read_data();
        int low_len, rv_cnt; logic [9:0] mb; bit rv_rise, clean;
        do_frame(10'h000, low_len, mb, rv_cnt, rv_rise, clean);  // slave write address 0x00
        do_frame(10'h1C3, low_len, mb, rv_cnt, rv_rise, clean);  // slave mem[0x00] = 0xC3
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL wr_data_no_update: rd_data got %h want 00", rd_data); end
        do_frame(10'h300, low_len, mb, rv_cnt, rv_rise, clean);
        n_checks++; if (low_len !== FRAME_RD) begin n_fail++; $display("FAIL rd_low_len: got %0d want %0d", low_len, FRAME_RD); end
        n_checks++; if (mb !== 10'h300)       begin n_fail++; $display("FAIL rd_mosi_bits: got %h want 300", mb); end
        n_checks++; if (clean !== 1'b1)       begin n_fail++; $display("FAIL rd_mosi_idle: MOSI nonzero outside shift"); end
        n_checks++; if (rv_rise !== 1'b1)     begin n_fail++; $display("FAIL rd_valid_at_rise: got %b want 1", rv_rise); end
        n_checks++; if (rv_cnt !== 1)         begin n_fail++; $display("FAIL rd_valid_width: got %0d cycles want 1", rv_cnt); end
        n_checks++; if (rd_data !== 8'hC3)    begin n_fail++; $display("FAIL rd_data: got %h want c3", rd_data); end
    endtask

    task automatic test_held_request();
        int acc, falls, rwb; logic prev_ss;
        acc = 0; falls = 0; rwb = 0;
        prev_ss = SS_n;
        cmd = 10'h0A5; cmd_valid = 1'b1;
        for (int i = 0; i < 300 && acc < 3; i++) begin
            if (cmd_ready) acc++;
            if (cmd_ready && busy) rwb++;
            if (prev_ss && !SS_n) falls++;
            prev_ss = SS_n;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (prev_ss && !SS_n) falls++;
            prev_ss = SS_n;
            if (!busy) break;
            @(negedge clk);
        end
        n_checks++; if (acc !== 3)   begin n_fail++; $display("FAIL held_accepts: got %0d want 3", acc); end
        n_checks++; if (falls !== 3) begin n_fail++; $display("FAIL held_frames: got %0d frames want 3", falls); end
        n_checks++; if ((rwb > 0) !== BUF_BUILD) begin n_fail++; $display("FAIL held_ready_while_busy: got %0d cycles, want nonzero=%b", rwb, BUF_BUILD); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_drain: busy got %b want 0", busy); end
        n_checks++; if (rd_data !== 8'hC3) begin n_fail++; $display("FAIL held_rd_data_hold: got %h want c3", rd_data); end
    endtask

    task automatic test_back_to_back();
        bit b1, b2; int k, lo1, hi, lo2;
        ss_q.delete();
        tr_on = 1'b1;
        send_cmd(10'h012, b1);
        send_cmd(10'h134, b2);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        @(negedge clk);
        tr_on = 1'b0;
        k = 0; lo1 = 0; hi = 0; lo2 = 0;
        while (k < ss_q.size() && ss_q[k])  k++;
        while (k < ss_q.size() && !ss_q[k]) begin lo1++; k++; end
        while (k < ss_q.size() && ss_q[k])  begin hi++;  k++; end
        while (k < ss_q.size() && !ss_q[k]) begin lo2++; k++; end
        n_checks++; if (lo1 !== FRAME_WR)  begin n_fail++; $display("FAIL b2b_first_low: got %0d want %0d", lo1, FRAME_WR); end
        n_checks++; if (hi !== GAP_HIGH)   begin n_fail++; $display("FAIL b2b_gap_high: got %0d want %0d", hi, GAP_HIGH); end
        n_checks++; if (lo2 !== FRAME_WR)  begin n_fail++; $display("FAIL b2b_second_low: got %0d want %0d", lo2, FRAME_WR); end
        n_checks++; if (b2 !== BUF_BUILD)  begin n_fail++; $display("FAIL b2b_accept_mid_frame: busy at accept got %b want %b", b2, BUF_BUILD); end
        n_checks++; if (rd_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_rd_data_hold: got %h want c3", rd_data); end
    endtask

    task automatic test_end_to_end();
        int low_len, rv_cnt; logic [9:0] mb; bit rv_rise, clean;
        do_frame(10'h010, low_len, mb, rv_cnt, rv_rise, clean);
        do_frame(10'h15A, low_len, mb, rv_cnt, rv_rise, clean);
        do_frame(10'h210, low_len, mb, rv_cnt, rv_rise, clean);
        n_checks++; if (rd_data !== 8'hC3) begin n_fail++; $display("FAIL e2e_rd_addr_no_update: got %h want c3", rd_data); end
        n_checks++; if (rv_cnt !== 0)      begin n_fail++; $display("FAIL e2e_rd_addr_strobe: got %0d want 0", rv_cnt); end
        do_frame(10'h300, low_len, mb, rv_cnt, rv_rise, clean);
        n_checks++; if (rd_data !== 8'h5A)    begin n_fail++; $display("FAIL e2e_rd_data: got %h want 5a", rd_data); end
        n_checks++; if (rv_cnt !== 1)         begin n_fail++; $display("FAIL e2e_rd_valid: got %0d want 1", rv_cnt); end
        n_checks++; if (low_len !== FRAME_RD) begin n_fail++; $display("FAIL e2e_low_len: got %0d want %0d", low_len, FRAME_RD); end
    endtask

    initial begin
        rst = 1'b1;
        cmd = '0;
        cmd_valid = 1'b0;
        test_reset();
        test_write_addr();
        test_reset_mid_frame();
        test_read_data();
        test_held_request();
        test_back_to_back();
        test_end_to_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
